// File: rtl/aq_mcb_scheduler.sv
// rtl/aq_mcb_scheduler.sv - buffers capture samples and writes them to SDRAM through the MCB command port
module aq_mcb_scheduler #(
    parameter int AXNUM = 24,
    parameter int ABITS = 20,
    parameter int FBITS = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               aq_ce_i,
    input  logic               rd_req_i,
    input  logic               vld_i,
    input  logic [AXNUM-1:0]   ax_data_i,
    output logic               mcb_ce_o,
    output logic               mcb_wr_o,
    input  logic               mcb_rdy_i,
    output logic [ABITS-2:0]   mcb_adr_o,
    output logic [31:0]        mcb_dat_o,
    output logic               aq_done_o,
    output logic               overflow_o,
    output logic [ABITS-2:0]   words_o,
    output logic [2:0]         tart_state
);

    localparam int AW    = ABITS - 1;
    localparam int DEPTH = 1 << FBITS;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_FLUSH   = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;

    localparam logic [FBITS:0] LP_FULL = {1'b1, {FBITS{1'b0}}};

    logic [2:0]       r_state;
    logic [2:0]       w_next;

    logic             w_start;
    logic             w_capturing;
    logic             w_draining;

    logic [31:0]      r_mem [0:DEPTH-1];
    logic [FBITS-1:0] r_wptr;
    logic [FBITS-1:0] r_rptr;
    logic [FBITS:0]   r_count;

    logic             r_ce;
    logic [AW-1:0]    r_adr;
    logic [31:0]      r_dat;

    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    r_words;
    logic             r_ovf;

    logic             w_full;
    logic             w_empty;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    logic             w_commit;
    logic             w_last;
    logic [31:0]      w_push_data;

    assign w_full      = (r_count == LP_FULL);
    assign w_empty     = (r_count == '0);
    assign w_push_req  = w_capturing && vld_i;
    // A pop in the same cycle does not free a slot: fullness is judged on the registered count.
    assign w_push      = w_push_req && !w_full;
    assign w_pop       = w_draining && !w_empty && !r_ce;
    assign w_commit    = r_ce && mcb_rdy_i;
    assign w_last      = w_commit && (r_adr == '1);
    assign w_push_data = 32'(ax_data_i);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the final address commit ends acquisition from either active state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (aq_ce_i) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_last)        w_next = S_DONE;
                else if (!aq_ce_i) w_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (w_last || (w_empty && !r_ce)) w_next = S_DONE;
            end
            S_DONE: begin
                if (rd_req_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded controls: sample intake, MCB draining, start pulse and done flag.
    always_comb begin
        w_start     = 1'b0;
        w_capturing = 1'b0;
        w_draining  = 1'b0;
        aq_done_o   = 1'b0;
        case (r_state)
            S_IDLE:    w_start = aq_ce_i;
            S_CAPTURE: begin
                w_capturing = 1'b1;
                w_draining  = 1'b1;
            end
            S_FLUSH:   w_draining = 1'b1;
            S_DONE:    aq_done_o = 1'b1;
            default:   ;
        endcase
    end

    // Sample storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    // FIFO pointers and occupancy, emptied at the start of every acquisition.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_start) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + FBITS'(1);
            if (w_pop)  r_rptr <= r_rptr + FBITS'(1);
            r_count <= r_count + (FBITS+1)'(w_push) - (FBITS+1)'(w_pop);
        end
    end

    // Pending MCB command: loaded on pop, held until the MCB accepts it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ce  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
        end else if (w_commit || !w_draining) begin
            r_ce  <= 1'b0;
        end else if (w_pop) begin
            r_ce  <= 1'b1;
            r_adr <= r_addr;
            r_dat <= r_mem[r_rptr];
        end
    end

    // Write address, committed-word count and sticky overflow flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_words <= '0;
            r_ovf   <= 1'b0;
        end else if (w_start) begin
            r_addr  <= '0;
            r_words <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_commit) begin
                r_addr <= r_addr + AW'(1);
                if (r_words != '1) r_words <= r_words + AW'(1);
            end
            if (w_push_req && w_full) r_ovf <= 1'b1;
        end
    end

    assign mcb_ce_o   = r_ce;
    assign mcb_wr_o   = r_ce;
    assign mcb_adr_o  = r_adr;
    assign mcb_dat_o  = r_dat;
    assign overflow_o = r_ovf;
    assign words_o    = r_words;
    assign tart_state = r_state;

endmodule
